// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the frame configuration loader.
// Holds the header sync byte, the header field positions, the
// configuration word width and the loader state encoding.
package frame_cfg_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [7:0] FRAME_SYNC = 8'hFA;

    localparam int unsigned SYNC_MSB = 31;
    localparam int unsigned SYNC_LSB = 24;
    localparam int unsigned COL_MSB  = 23;
    localparam int unsigned COL_LSB  = 16;
    localparam int unsigned FRM_MSB  = 15;
    localparam int unsigned FRM_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STROBE
    } state_t;

endpackage

// File: rtl/frame_cfg_header_decode.sv
// Combinational header decoder for the frame configuration loader.
// Ports:
//   in_data   - candidate header word
//   hdr_ok    - sync byte matches and column/frame indices are in range
//   col_idx   - raw column field
//   frame_idx - raw frame field
module frame_cfg_header_decode
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NUM_COLS           = 8,
    parameter int unsigned MAX_FRAMES_PER_COL = 20
) (
    input  logic [WORD_W-1:0] in_data,
    output logic              hdr_ok,
    output logic [7:0]        col_idx,
    output logic [7:0]        frame_idx
);

    // Low byte of the header is reserved and intentionally ignored.
    logic unused_rsvd;
    assign unused_rsvd = ^in_data[7:0];

    always_comb begin
        col_idx   = in_data[COL_MSB:COL_LSB];
        frame_idx = in_data[FRM_MSB:FRM_LSB];
        hdr_ok    = (in_data[SYNC_MSB:SYNC_LSB] == FRAME_SYNC)
                 && (32'(col_idx)   < NUM_COLS)
                 && (32'(frame_idx) < MAX_FRAMES_PER_COL);
    end

endmodule

// File: rtl/frame_config_loader.sv
// Frame-based configuration writer. Accepts a header word followed by
// one data word per fabric row, then commits the assembled column frame
// with a single-cycle FrameStrobe/ColSelect pulse.
// Ports:
//   CLK, resetn      - configuration clock, synchronous active-low reset
//   in_data/in_valid/in_ready - word stream handshake
//   err_clr          - clears the sticky header error
//   FrameData        - assembled frame, row r at bits [32r+31:32r]
//   FrameStrobe      - one-hot frame write pulse
//   ColSelect        - one-hot column select, valid with the strobe
//   busy             - loader is in LOAD or STROBE
//   err              - sticky header error
//   frames_done      - count of committed frames (wraps)
module frame_config_loader
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NUM_ROWS           = 4,
    parameter int unsigned NUM_COLS           = 8,
    parameter int unsigned MAX_FRAMES_PER_COL = 20
) (
    input  logic                           CLK,
    input  logic                           resetn,
    input  logic [WORD_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           err_clr,
    output logic [NUM_ROWS*WORD_W-1:0]     FrameData,
    output logic [MAX_FRAMES_PER_COL-1:0]  FrameStrobe,
    output logic [NUM_COLS-1:0]            ColSelect,
    output logic                           busy,
    output logic                           err,
    output logic [15:0]                    frames_done
);

    localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned FRM_W = (MAX_FRAMES_PER_COL > 1) ? $clog2(MAX_FRAMES_PER_COL) : 1;

    state_t                           state;
    logic [ROW_W-1:0]                 row_cnt;
    logic [COL_W-1:0]                 col_q;
    logic [FRM_W-1:0]                 frm_q;
    logic [NUM_ROWS-1:0][WORD_W-1:0]  rows_q;

    logic       hdr_ok;
    logic [7:0] col_idx;
    logic [7:0] frame_idx;
    logic       accept;

    frame_cfg_header_decode #(
        .NUM_COLS           (NUM_COLS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL)
    ) u_hdr (
        .in_data   (in_data),
        .hdr_ok    (hdr_ok),
        .col_idx   (col_idx),
        .frame_idx (frame_idx)
    );

    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign FrameData = rows_q;

    // Unused high bits of the decoded indices: the header is range-checked
    // before latching, so only the low bits carry information.
    logic unused_idx;
    assign unused_idx = ^{col_idx, frame_idx};

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= IDLE;
            row_cnt     <= '0;
            col_q       <= '0;
            frm_q       <= '0;
            rows_q      <= '0;
            FrameStrobe <= '0;
            ColSelect   <= '0;
            err         <= 1'b0;
            frames_done <= '0;
        end else begin
            FrameStrobe <= '0;
            ColSelect   <= '0;

            // A header error later in this block overrides the clear.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (hdr_ok) begin
                            col_q   <= col_idx[COL_W-1:0];
                            frm_q   <= frame_idx[FRM_W-1:0];
                            row_cnt <= '0;
                            state   <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        rows_q[row_cnt] <= in_data;
                        if (row_cnt == ROW_W'(NUM_ROWS - 1)) begin
                            row_cnt            <= '0;
                            state              <= STROBE;
                            // Strobe flops are loaded here so the pulse
                            // occupies exactly the STROBE cycle.
                            FrameStrobe[frm_q] <= 1'b1;
                            ColSelect[col_q]   <= 1'b1;
                            frames_done        <= frames_done + 16'd1;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                STROBE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// Scoreboard bench for frame_config_loader: each committed frame pushes
// its expected strobe/column/data/count, and a monitor pops on every
// observed strobe pulse.
module tb_frame_config_loader;

    localparam int NR = 4;
    localparam int NC = 8;
    localparam int NF = 20;

    logic              CLK;
    logic              resetn;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic              err_clr;
    logic [NR*32-1:0]  FrameData;
    logic [NF-1:0]     FrameStrobe;
    logic [NC-1:0]     ColSelect;
    logic              busy;
    logic              err;
    logic [15:0]       frames_done;

    frame_config_loader #(
        .NUM_ROWS           (NR),
        .NUM_COLS           (NC),
        .MAX_FRAMES_PER_COL (NF)
    ) dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .err_clr     (err_clr),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ColSelect   (ColSelect),
        .busy        (busy),
        .err         (err),
        .frames_done (frames_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NF-1:0]    strobe;
        logic [NC-1:0]    col;
        logic [NR*32-1:0] data;
        logic [15:0]      done;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          strobe_cnt = 0;
    int          last_strobe_cyc = 0;
    int          prev_strobe_cyc = 0;
    logic [15:0] exp_done = 16'd0;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [NR*32-1:0] act,
                         input logic [NR*32-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with a strobe or column bit set must match the
    // oldest outstanding expected frame.
    always @(negedge CLK) begin
        if (FrameStrobe != '0 || ColSelect != '0) begin
            strobe_cnt++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got strobe=%0h col=%0h expected none",
                         FrameStrobe, ColSelect);
            end else begin
                mon_e = sbq.pop_front();
                check("frame_strobe", (NR*32)'(FrameStrobe), (NR*32)'(mon_e.strobe));
                check("col_select",   (NR*32)'(ColSelect),   (NR*32)'(mon_e.col));
                check("frame_data",   FrameData,             mon_e.data);
                check("frames_done",  (NR*32)'(frames_done), (NR*32)'(mon_e.done));
                check("ready_in_strobe", (NR*32)'(in_ready), '0);
                check("busy_in_strobe",  (NR*32)'(busy),     (NR*32)'(1));
            end
        end
    end

    // Drive a word from a negedge and return at the negedge after the
    // edge on which it was accepted. in_valid stays high on return.
    task automatic send(input logic [31:0] w);
        logic acc;
        int   n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        forever begin
            acc = in_ready;
            @(posedge CLK);
            @(negedge CLK);
            if (acc) return;
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got no acceptance of %0h expected acceptance", w);
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_exp(input int col, input int frm, input logic [NR*32-1:0] d);
        exp_t e;
        e.strobe      = '0;
        e.strobe[frm] = 1'b1;
        e.col         = '0;
        e.col[col]    = 1'b1;
        e.data        = d;
        exp_done      = exp_done + 16'd1;
        e.done        = exp_done;
        sbq.push_back(e);
    endtask

    task automatic send_data(input logic [NR*32-1:0] d, input bit gap);
        for (int i = 0; i < NR; i++) begin
            send(d[i*32 +: 32]);
            if (gap) begin
                check("busy_gapped", (NR*32)'(busy), (NR*32)'(1));
                if (i != NR - 1) idle(1);
            end
        end
    endtask

    task automatic send_frame(input int col, input int frm,
                              input logic [NR*32-1:0] d, input bit gap);
        push_exp(col, frm, d);
        send({8'hFA, 8'(col), 8'(frm), 8'h00});
        if (gap) begin
            check("busy_after_hdr", (NR*32)'(busy), (NR*32)'(1));
            idle(1);
        end
        send_data(d, gap);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("strobes_outstanding", (NR*32)'(sbq.size()), '0);
    endtask

    initial begin
        int s0;
        logic [NR*32-1:0] d;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        err_clr  = 1'b0;
        repeat (2) @(negedge CLK);

        check("rst_frame_data",  FrameData, '0);
        check("rst_strobe",      (NR*32)'(FrameStrobe), '0);
        check("rst_col",         (NR*32)'(ColSelect), '0);
        check("rst_busy",        (NR*32)'(busy), '0);
        check("rst_err",         (NR*32)'(err), '0);
        check("rst_frames_done", (NR*32)'(frames_done), '0);
        check("rst_in_ready",    (NR*32)'(in_ready), (NR*32)'(1));
        resetn = 1'b1;
        @(negedge CLK);

        // Reset in the middle of LOAD discards the partial frame.
        send(32'hFA03_0500);
        send(32'hA1A1_A1A1);
        send(32'hA2A2_A2A2);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge CLK);
        resetn = 1'b1;
        check("midrst_frame_data",  FrameData, '0);
        check("midrst_frames_done", (NR*32)'(frames_done), '0);
        check("midrst_in_ready",    (NR*32)'(in_ready), (NR*32)'(1));
        check("midrst_busy",        (NR*32)'(busy), '0);
        idle(6);
        check("midrst_no_strobe",   (NR*32)'(strobe_cnt), '0);

        // Single frame, valid held high.
        d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        send_frame(2, 7, d, 1'b0);
        idle(3);
        wait_drain();
        check("single_data",      FrameData, d);
        check("single_done",      (NR*32)'(frames_done), (NR*32)'(1));
        check("single_strobes",   (NR*32)'(strobe_cnt), (NR*32)'(1));
        check("single_strobe_off", (NR*32)'(FrameStrobe), '0);

        // Two frames back to back with valid high throughout.
        s0 = strobe_cnt;
        send_frame(5, 3,  {32'hB4, 32'hB3, 32'hB2, 32'hB1}, 1'b0);
        send_frame(0, 0,  {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 1'b0);
        idle(3);
        wait_drain();
        check("b2b_strobes", (NR*32)'(strobe_cnt - s0), (NR*32)'(2));
        check("b2b_spacing", (NR*32)'(last_strobe_cyc - prev_strobe_cyc), (NR*32)'(6));

        // Header errors.
        s0 = strobe_cnt;
        send(32'hAB00_0000);
        idle(1);
        check("bad_sync_err",  (NR*32)'(err), (NR*32)'(1));
        check("bad_sync_busy", (NR*32)'(busy), '0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("err_clr",       (NR*32)'(err), '0);
        send(32'hFA08_0000);
        idle(1);
        check("bad_col_err",   (NR*32)'(err), (NR*32)'(1));
        check("bad_col_busy",  (NR*32)'(busy), '0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        send(32'hFA00_1400);
        idle(1);
        check("bad_frm_err",   (NR*32)'(err), (NR*32)'(1));
        check("bad_frm_busy",  (NR*32)'(busy), '0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;
        check("err_clr2",      (NR*32)'(err), '0);
        err_clr = 1'b1;
        send(32'h12FA_0000);
        err_clr = 1'b0;
        idle(1);
        check("clr_vs_set",    (NR*32)'(err), (NR*32)'(1));
        check("err_no_strobe", (NR*32)'(strobe_cnt - s0), '0);
        err_clr = 1'b1;
        @(negedge CLK);
        err_clr = 1'b0;

        // Gapped input on the highest legal column/frame.
        s0 = strobe_cnt;
        d = {32'hD0D0_0004, 32'hD0D0_0003, 32'hD0D0_0002, 32'hD0D0_0001};
        send_frame(7, 19, d, 1'b1);
        idle(3);
        wait_drain();
        check("gap_strobes", (NR*32)'(strobe_cnt - s0), (NR*32)'(1));
        check("gap_err",     (NR*32)'(err), '0);

        // Next header alone leaves FrameData untouched; loader waits.
        push_exp(1, 1, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
        send(32'hFA01_0100);
        idle(5);
        check("hold_data", FrameData, d);
        check("hold_busy", (NR*32)'(busy), (NR*32)'(1));
        send_data({32'hE4, 32'hE3, 32'hE2, 32'hE1}, 1'b0);
        idle(3);
        wait_drain();

        // frames_done wrap.
        force dut.frames_done = 16'hFFFF;
        @(negedge CLK);
        release dut.frames_done;
        exp_done = 16'hFFFF;
        send_frame(4, 10, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1'b0);
        idle(3);
        wait_drain();
        check("wrap_done", (NR*32)'(frames_done), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_config_loader.md
Name: frame_config_loader

Overview:
Frame-based configuration writer. It is the producer side of the ConfigBits interface that tile primitives (LUTs, MUX8 blocks, switch matrices) consume.
- Accepts a 32-bit word stream over a valid/ready handshake.
- Decodes a header word, assembles one column frame (one 32-bit word per row) and commits it with a single-cycle FrameStrobe/ColSelect pulse.
- Sits between the bitstream front end (UART/bit-bang FSM) and the fabric's frame-data/frame-strobe distribution.

Parameters:
- NUM_ROWS, 4, fabric rows; FrameData is NUM_ROWS*32 bits.
- NUM_COLS, 8, fabric columns; width of ColSelect.
- MAX_FRAMES_PER_COL, 20, frames per column; width of FrameStrobe.

Ports:
- CLK  in  1  fabric configuration clock
- resetn  in  1  synchronous, active-low reset
- in_data  in  32  header or data word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- err_clr  in  1  clears sticky err
- FrameData  out  NUM_ROWS*32  frame contents; row r occupies bits [32r+31:32r]
- FrameStrobe  out  MAX_FRAMES_PER_COL  one-hot frame write pulse
- ColSelect  out  NUM_COLS  one-hot column select, valid with strobe
- busy  out  1  high in LOAD or STROBE
- err  out  1  sticky header error
- frames_done  out  16  count of committed frames

Behaviour:
- Reset (resetn=0 at a CLK edge):
  - state=IDLE; all outputs 0 except in_ready, which is 1 after reset.
  - FrameData=0; err=0; frames_done=0.
  - Reset mid-LOAD discards the partial frame; no strobe is issued.
- Handshake:
  - A word transfers when in_valid && in_ready at a rising CLK edge.
  - in_ready = (state==IDLE || state==LOAD).
- Header word format:
  - [31:24] = 8'hFA (sync).
  - [23:16] = column index.
  - [15:8] = frame index.
  - [7:0] = reserved, ignored.
- IDLE:
  - Valid header accepted: latch col and frame, clear row counter, go to LOAD.
  - Invalid header (sync != FA, col >= NUM_COLS, or frame >= MAX_FRAMES_PER_COL): word dropped, err<=1, stay in IDLE.
- LOAD:
  - Each accepted word is written to row row_cnt of FrameData, then row_cnt increments.
  - The first data word goes to row 0 (ascending order).
  - Rows not yet written keep their previous values.
  - On acceptance of row NUM_ROWS-1, go to STROBE.
  - No sync check is done on data words.
- STROBE (exactly 1 cycle):
  - FrameStrobe[frame]=1 and ColSelect[col]=1; all other bits 0.
  - frames_done increments; it wraps FFFF->0000.
  - Next state is IDLE.
- Outside STROBE, FrameStrobe and ColSelect are all-zero.
- FrameData is stable during STROBE and holds its value until the next accepted data word.
- Latency:
  - Last data word accepted at edge N -> strobe high in cycle N..N+1 -> in_ready high again after edge N+1.
  - Minimum frame cost is NUM_ROWS+2 cycles (header + NUM_ROWS data + STROBE).
- busy = (state != IDLE).
- err:
  - Sticky; cleared by err_clr=1.
  - If err_clr coincides with a new header error, set wins (err=1).
- in_valid low during LOAD: the loader waits indefinitely. There is no timeout.
- Outputs are registered: FrameStrobe, ColSelect and FrameData come straight from flops.

Decomposition:
- Package frame_cfg_pkg holds:
  - FRAME_SYNC = 8'hFA
  - header field positions (SYNC_MSB/LSB, COL_MSB/LSB, FRM_MSB/LSB)
  - state enum {IDLE, LOAD, STROBE}
  - frame word width = 32
- One sub-module is natural: frame_cfg_header_decode.
  - Combinational.
  - Inputs: in_data and parameters.
  - Outputs: hdr_ok, col_idx, frame_idx.
  - The FSM, row counter, FrameData register and strobe generation stay in the top.

Test Plan:
1. Reset mid-LOAD: header 0xFA03_0500, two data words, then resetn=0 for 1 cycle -> no FrameStrobe ever pulses; FrameData=0; frames_done=0; in_ready=1 after reset.
2. Single frame: header 0xFA02_0700, data 0x11111111, 0x22222222, 0x33333333, 0x44444444 with in_valid held high -> one cycle later FrameStrobe=1<<7 and ColSelect=1<<2 for exactly 1 cycle; FrameData=0x44444444_33333333_22222222_11111111; frames_done=1.
3. Backpressure: two frames back-to-back with in_valid high throughout -> in_ready=0 only during each STROBE cycle; second strobe 6 cycles after the first; no word lost or duplicated.
4. Header errors:
   - 0xAB00_0000 (bad sync) -> err=1, no strobe, state IDLE.
   - 0xFA08_0000 (col=8) -> err stays 1.
   - 0xFA00_1400 (frame=20) -> err stays 1.
   - err_clr pulse -> err=0.
   - err_clr coincident with a bad header -> err=1.
5. Gapped input: in_valid toggles 1/0 each cycle across a full frame -> rows land in order; strobe occurs exactly once; busy stays high from header acceptance through STROBE.
6. Counter wrap: force frames_done to 0xFFFF via 65535 frames (or a backdoor force), commit one more frame -> frames_done=0x0000.
